page_table_walker: RTL and testbench

//  Hardware page-table walker (HPTW) for Sv39. It is the supplier side of the MMU TLB refill interface.
//  It consumes a TLB miss, fetches PTEs from memory through a single request/response port, and returns the leaf.
//  It then drives PTE, PageTypeWriteVal and a one-cycle TLBWrite back into the MMU, or reports a page/access fault.
//  One instance sits between each MMU (I and D) and the shared memory arbiter.

---
 rtl/page_table_walker.sv | 197 +++++++++++++++++++
 tb/tb_page_table_walker.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/page_table_walker.sv
// Sv39 hardware page-table walker: consumes an MMU TLB miss, reads PTEs
// over one request/response port and returns the leaf or a fault.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   SATP_REGW         : satp CSR (MODE [63:60], root PPN [43:0])
//   TLBMiss, VAdr     : miss request and its virtual address
//   TLBFlush          : aborts an in-flight walk
//   MemReq, MemPAdr   : PTE read request and its physical address
//   MemReady          : request accepted this cycle
//   MemRdValid/Data   : PTE read response
//   MemErr            : bus error, qualified by MemRdValid
//   PTE, PageTypeWriteVal, TLBWrite : leaf fill into the TLB
//   WalkerPageFault, WalkerAccessFault : one-cycle fault strobes
//   Busy              : walk in progress
module page_table_walker #(
  parameter int XLEN    = 64,
  parameter int PA_BITS = 56
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [XLEN-1:0]    SATP_REGW,
  input  logic               TLBMiss,
  input  logic [XLEN-1:0]    VAdr,
  input  logic               TLBFlush,
  output logic               MemReq,
  output logic [PA_BITS-1:0] MemPAdr,
  input  logic               MemReady,
  input  logic               MemRdValid,
  input  logic [XLEN-1:0]    MemRdData,
  input  logic               MemErr,
  output logic [XLEN-1:0]    PTE,
  output logic [1:0]         PageTypeWriteVal,
  output logic               TLBWrite,
  output logic               WalkerPageFault,
  output logic               WalkerAccessFault,
  output logic               Busy
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    LEAF,
    PFAULT,
    AFAULT,
    DONE,
    DRAIN
  } state_t;

  state_t             state_q;
  logic [1:0]         level_q;
  logic               memreq_q;
  logic [PA_BITS-1:0] adr_q;
  logic [XLEN-1:0]    pte_q;
  logic [1:0]         ptype_q;
  logic               tlbw_q;
  logic               pf_q;
  logic               af_q;
  logic               busy_q;

  logic               start_d;
  logic [55:0]        root_adr_d;
  logic [55:0]        next_adr_d;
  logic [8:0]         vpn_nxt_d;
  logic               bad_d;
  logic               leaf_d;
  logic               misal_d;
  logic               unused_bits;

  assign unused_bits = ^{VAdr[63:39], VAdr[11:0],
                         SATP_REGW[59:44]};

  assign start_d = TLBMiss & ~TLBFlush &
                   (SATP_REGW[63:60] == 4'd8);

  assign root_adr_d = {SATP_REGW[43:0],
                       VAdr[38:30], 3'b000};

  // Index for the level we are about to descend into.
  assign vpn_nxt_d = (level_q == 2'd2) ? VAdr[29:21]
                                       : VAdr[20:12];

  assign next_adr_d = {MemRdData[53:10],
                       vpn_nxt_d, 3'b000};

  // Invalid, write-without-read, or reserved high bits set.
  assign bad_d = ~MemRdData[0] |
                 (~MemRdData[1] & MemRdData[2]) |
                 (|MemRdData[63:54]);

  assign leaf_d = MemRdData[1] | MemRdData[3];

  // A superpage leaf must have zero PPN slices below its level.
  always_comb begin
    misal_d = 1'b0;
    if (level_q == 2'd2)
      misal_d = |MemRdData[27:10];
    else if (level_q == 2'd1)
      misal_d = |MemRdData[18:10];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      level_q  <= 2'd2;
      memreq_q <= 1'b0;
      adr_q    <= '0;
      pte_q    <= '0;
      ptype_q  <= 2'd0;
      tlbw_q   <= 1'b0;
      pf_q     <= 1'b0;
      af_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      memreq_q <= 1'b0;
      tlbw_q   <= 1'b0;
      pf_q     <= 1'b0;
      af_q     <= 1'b0;
      busy_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_d) begin
            state_q  <= REQ;
            level_q  <= 2'd2;
            adr_q    <= root_adr_d[PA_BITS-1:0];
            memreq_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        REQ: begin
          // An accepted request still owes us a response.
          if (TLBFlush) begin
            state_q <= MemReady ? DRAIN : IDLE;
          end else if (MemReady) begin
            state_q <= WAIT;
            busy_q  <= 1'b1;
          end else begin
            memreq_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        WAIT: begin
          busy_q <= 1'b1;
          if (TLBFlush) begin
            busy_q  <= 1'b0;
            state_q <= MemRdValid ? IDLE : DRAIN;
          end else if (MemRdValid) begin
            if (MemErr) begin
              state_q <= AFAULT;
              af_q    <= 1'b1;
            end else if (bad_d |
                         (leaf_d & misal_d) |
                         (~leaf_d &
                          (level_q == 2'd0))) begin
              state_q <= PFAULT;
              pf_q    <= 1'b1;
            end else if (leaf_d) begin
              state_q <= LEAF;
              tlbw_q  <= 1'b1;
              pte_q   <= MemRdData;
              ptype_q <= level_q;
            end else begin
              state_q  <= REQ;
              level_q  <= level_q - 2'd1;
              adr_q    <= next_adr_d[PA_BITS-1:0];
              memreq_q <= 1'b1;
            end
          end
        end
        LEAF, PFAULT, AFAULT: begin
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        DRAIN: begin
          if (MemRdValid)
            state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign MemReq            = memreq_q;
  assign MemPAdr           = adr_q;
  assign PTE               = pte_q;
  assign PageTypeWriteVal  = ptype_q;
  assign TLBWrite          = tlbw_q;
  assign WalkerPageFault   = pf_q;
  assign WalkerAccessFault = af_q;
  assign Busy              = busy_q;

endmodule

// File: tb/tb_page_table_walker.sv
// Self-checking bench for page_table_walker: table-driven walks with a
// zero-wait memory responder plus hand-written abort/reset sequences.
module tb_page_table_walker;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] SATP_REGW;
  logic        TLBMiss;
  logic [63:0] VAdr;
  logic        TLBFlush;
  logic        MemReq;
  logic [55:0] MemPAdr;
  logic        MemReady;
  logic        MemRdValid;
  logic [63:0] MemRdData;
  logic        MemErr;
  logic [63:0] PTE;
  logic [1:0]  PageTypeWriteVal;
  logic        TLBWrite;
  logic        WalkerPageFault;
  logic        WalkerAccessFault;
  logic        Busy;

  always #5 clk = ~clk;

  page_table_walker #(
    .XLEN(64),
    .PA_BITS(56)
  ) dut (
    .clk(clk),
    .reset(reset),
    .SATP_REGW(SATP_REGW),
    .TLBMiss(TLBMiss),
    .VAdr(VAdr),
    .TLBFlush(TLBFlush),
    .MemReq(MemReq),
    .MemPAdr(MemPAdr),
    .MemReady(MemReady),
    .MemRdValid(MemRdValid),
    .MemRdData(MemRdData),
    .MemErr(MemErr),
    .PTE(PTE),
    .PageTypeWriteVal(PageTypeWriteVal),
    .TLBWrite(TLBWrite),
    .WalkerPageFault(WalkerPageFault),
    .WalkerAccessFault(WalkerAccessFault),
    .Busy(Busy)
  );

  typedef struct packed {
    logic [63:0] satp;
    logic [63:0] vadr;
    logic [63:0] p0;
    logic [63:0] p1;
    logic [63:0] p2;
    logic [2:0]  err;
    logic [2:0]  res;
    logic [1:0]  lvl;
    int          nreads;
    int          lat;
  } vec_t;

  localparam logic [63:0] SATP = 64'h8000_0000_0008_0000;
  localparam logic [63:0] VA0  = 64'h0000_0040_0020_3000;
  localparam logic [63:0] VA1  = 64'h0000_003F_FFFF_F000;
  localparam logic [2:0] R_LEAF = 3'b100;
  localparam logic [2:0] R_PF   = 3'b010;
  localparam logic [2:0] R_AF   = 3'b001;

  int passed = 0;
  int total  = 0;
  int strobe_cnt = 0;
  logic [55:0] exp_q[$];
  vec_t vecs[10];

  always @(posedge clk)
    if (TLBWrite || WalkerPageFault || WalkerAccessFault)
      strobe_cnt++;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [63:0] ptr(input logic [43:0] p);
    return {10'd0, p, 10'h001};
  endfunction

  function automatic logic [63:0] lf(input logic [43:0] p);
    return {10'd0, p, 10'h0CF};
  endfunction

  function automatic vec_t mk(
    input logic [63:0] va, input logic [63:0] p0,
    input logic [63:0] p1, input logic [63:0] p2,
    input logic [2:0] err, input logic [2:0] res,
    input logic [1:0] lvl, input int nr, input int lat);
    vec_t v;
    v.satp = SATP; v.vadr = va;
    v.p0 = p0; v.p1 = p1; v.p2 = p2;
    v.err = err; v.res = res; v.lvl = lvl;
    v.nreads = nr; v.lat = lat;
    return v;
  endfunction

  function automatic logic [63:0] getp(input vec_t v,
                                       input int i);
    if (i == 0) return v.p0;
    if (i == 1) return v.p1;
    return v.p2;
  endfunction

  // Sv39 reference address for read i of a walk.
  function automatic logic [55:0] exp_adr(input vec_t v,
                                          input int i);
    logic [63:0] p;
    logic [63:0] va;
    logic [8:0]  vpn;
    va = v.vadr;
    if (i == 0) return {v.satp[43:0], va[38:30], 3'b000};
    p = getp(v, i - 1);
    vpn = (i == 1) ? va[29:21] : va[20:12];
    return {p[53:10], vpn, 3'b000};
  endfunction

  task automatic idle_inputs();
    MemReady = 1'b0; MemRdValid = 1'b0;
    MemErr = 1'b0; MemRdData = '0;
  endtask

  task automatic run_walk(input vec_t v, input string nm);
    int cyc, reqs, idx;
    bit pend, done;
    logic [63:0] d;
    logic [55:0] a;
    exp_q.delete();
    for (int i = 0; i < v.nreads; i++)
      exp_q.push_back(exp_adr(v, i));
    SATP_REGW = v.satp; VAdr = v.vadr; TLBMiss = 1'b1;
    cyc = 0; reqs = 0; idx = 0; pend = 0; done = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      idle_inputs();
      if (TLBWrite | WalkerPageFault | WalkerAccessFault) begin
        done = 1;
        check({nm, " result"},
              {61'd0, TLBWrite, WalkerPageFault,
               WalkerAccessFault}, {61'd0, v.res});
        check({nm, " latency"}, cyc, v.lat);
        check({nm, " busy"}, Busy, 1);
        if (v.res == R_LEAF) begin
          d = getp(v, v.nreads - 1);
          check({nm, " pte"}, PTE, d);
          check({nm, " ptype"}, PageTypeWriteVal, v.lvl);
        end
      end else if (pend) begin
        pend = 0;
        d = getp(v, idx);
        MemRdValid = 1'b1; MemRdData = d;
        MemErr = v.err[idx]; idx++;
      end else if (MemReq) begin
        reqs++; MemReady = 1'b1; pend = 1;
        if (exp_q.size() == 0) begin
          check({nm, " extra_req"}, reqs, v.nreads);
        end else begin
          a = exp_q.pop_front();
          check({nm, " adr"}, MemPAdr, a);
        end
      end
    end
    if (!done) check({nm, " timeout"}, cyc, v.lat);
    check({nm, " nreads"}, reqs, v.nreads);
    @(posedge clk); @(negedge clk);
    check({nm, " strobe_1cyc"},
          {TLBWrite, WalkerPageFault, WalkerAccessFault, Busy},
          0);
    TLBMiss = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    int s0;
    int nreq;
    reset = 1'b1; TLBMiss = 1'b0; TLBFlush = 1'b0;
    SATP_REGW = SATP; VAdr = VA0;
    idle_inputs();

    vecs[0] = mk(VA0, ptr(44'h80001), ptr(44'h80002),
                 lf(44'h80010), 3'b000, R_LEAF, 2'd0, 3, 7);
    vecs[1] = mk(VA0, 64'h0000_0000_2000_00CF, '0, '0,
                 3'b000, R_LEAF, 2'd2, 1, 3);
    vecs[2] = mk(VA0, ptr(44'h80001), lf(44'h00001), '0,
                 3'b000, R_PF, 2'd1, 2, 5);
    vecs[3] = mk(VA0, ptr(44'h80001), lf(44'h00200), '0,
                 3'b000, R_LEAF, 2'd1, 2, 5);
    vecs[4] = mk(VA0, ptr(44'h80001), 64'h0, '0,
                 3'b000, R_PF, 2'd1, 2, 5);
    vecs[5] = mk(VA0, 64'h5, '0, '0,
                 3'b000, R_PF, 2'd2, 1, 3);
    vecs[6] = mk(VA0, lf(44'h80000), '0, '0,
                 3'b001, R_AF, 2'd2, 1, 3);
    vecs[7] = mk(VA0, 64'h0040_0000_0000_00CF, '0, '0,
                 3'b000, R_PF, 2'd2, 1, 3);
    vecs[8] = mk(VA0, ptr(44'h80001), ptr(44'h80002),
                 ptr(44'h80003), 3'b000, R_PF, 2'd0, 3, 7);
    vecs[9] = mk(VA1, ptr(44'hABCDE), ptr(44'h12345),
                 lf(44'h0F0F0), 3'b000, R_LEAF, 2'd0, 3, 7);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs",
          {MemReq, TLBWrite, WalkerPageFault,
           WalkerAccessFault, Busy, PageTypeWriteVal}, 0);
    check("reset_pte", PTE, 0);
    check("reset_adr", MemPAdr, 0);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);

    for (int i = 0; i < 10; i++)
      run_walk(vecs[i], $sformatf("vec%0d", i));

    // Flush while waiting for the response.
    s0 = strobe_cnt;
    SATP_REGW = SATP; VAdr = VA0; TLBMiss = 1'b1;
    @(posedge clk); @(negedge clk);
    check("fw_req", MemReq, 1);
    MemReady = 1'b1;
    @(posedge clk); @(negedge clk);
    MemReady = 1'b0;
    check("fw_wait_busy", Busy, 1);
    TLBFlush = 1'b1; TLBMiss = 1'b0;
    @(posedge clk); @(negedge clk);
    TLBFlush = 1'b0;
    check("fw_drain", {MemReq, Busy}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    MemRdValid = 1'b1; MemRdData = 64'h0000_0000_2000_00CF;
    @(posedge clk); @(negedge clk);
    idle_inputs();
    @(posedge clk); @(negedge clk);
    check("fw_no_strobe", strobe_cnt, s0);
    run_walk(vecs[1], "fw_rewalk");

    // Flush while the request is pending.
    s0 = strobe_cnt;
    TLBMiss = 1'b1;
    @(posedge clk); @(negedge clk);
    check("fr_req", MemReq, 1);
    TLBFlush = 1'b1;
    @(posedge clk); @(negedge clk);
    TLBFlush = 1'b0; TLBMiss = 1'b0;
    check("fr_abort", {MemReq, Busy}, 0);
    @(posedge clk); @(negedge clk);
    check("fr_no_strobe", strobe_cnt, s0);

    // Bare mode: the walker must not start.
    SATP_REGW = 64'h0000_0000_0008_0000; TLBMiss = 1'b1;
    nreq = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      if (MemReq || Busy) nreq++;
    end
    check("bare_idle", nreq, 0);
    TLBMiss = 1'b0; SATP_REGW = SATP;

    // Reset in the middle of a walk; late response ignored.
    s0 = strobe_cnt;
    TLBMiss = 1'b1;
    @(posedge clk); @(negedge clk);
    MemReady = 1'b1;
    @(posedge clk); @(negedge clk);
    MemReady = 1'b0; reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0; TLBMiss = 1'b0;
    check("rst_mid", {MemReq, Busy}, 0);
    MemRdValid = 1'b1; MemRdData = 64'h0000_0000_2000_00CF;
    @(posedge clk); @(negedge clk);
    idle_inputs();
    @(posedge clk); @(negedge clk);
    check("rst_no_strobe", strobe_cnt, s0);
    check("rst_pte", PTE, 0);
    run_walk(vecs[0], "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
